// File: rtl/mac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : mac_pkg                                                        |
// | Purpose : Shared defaults and the result quantizer for the MAC drain     |
// |           stage. quantize() rounds half up, arithmetic-shifts right and  |
// |           saturates to a signed out_w-bit range.                         |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
package mac_pkg;

  localparam int c_acc_w_def = 32;
  localparam int c_out_w_def = 16;

  localparam logic signed [c_out_w_def-1:0] c_sat_max = 16'sh7FFF;
  localparam logic signed [c_out_w_def-1:0] c_sat_min = 16'sh8000;

  typedef struct packed {
    logic               sat;
    logic signed [63:0] value;
  } quant_t;

  // acc is the accumulator sign-extended to 64 bits, so the rounding add can
  // never overflow for any accumulator narrower than 64 bits.
  function automatic quant_t quantize(input logic signed [63:0] acc,
                                      input int unsigned        shift,
                                      input int unsigned        out_w);
    logic signed [63:0] rnd;
    logic signed [63:0] r;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    quant_t             q;
    rnd = (shift == 0) ? 64'sd0 : (64'sd1 <<< (shift - 32'd1));
    r   = (acc + rnd) >>> shift;
    hi  = (64'sd1 <<< (out_w - 32'd1)) - 64'sd1;
    lo  = -(64'sd1 <<< (out_w - 32'd1));
    q.sat = (r > hi) || (r < lo);
    if (r > hi) begin
      q.value = hi;
    end else if (r < lo) begin
      q.value = lo;
    end else begin
      q.value = r;
    end
    return q;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mac_result_drain_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface : mac_result_drain_if                                          |
// | Purpose   : Accumulate-beat input handshake, quantized-result output     |
// |             handshake and status of the MAC result drain.                |
// | Ports     : acc_in/acc_valid/acc_ready - beat stream from the MAC        |
// |             mac_clear                  - zero the MAC at next edge       |
// |             out_data/out_valid/out_ready - result stream to consumer     |
// |             sat_flag, beat_cnt         - status                          |
// | Modports  : master - the drain stage; slave - MAC/consumer environment   |
// | Revision  : 1.0  initial release                                         |
// +--------------------------------------------------------------------------+
interface mac_result_drain_if #(
  parameter int ACC_W = 32,
  parameter int OUT_W = 16,
  parameter int LEN   = 4
);
  localparam int CNT_W = $clog2(LEN) + 1;

  logic [ACC_W-1:0] acc_in;
  logic             acc_valid;
  logic             acc_ready;
  logic             mac_clear;
  logic [OUT_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             sat_flag;
  logic [CNT_W-1:0] beat_cnt;

  modport master (
    input  acc_in, acc_valid, out_ready,
    output acc_ready, mac_clear, out_data, out_valid, sat_flag, beat_cnt
  );

  modport slave (
    output acc_in, acc_valid, out_ready,
    input  acc_ready, mac_clear, out_data, out_valid, sat_flag, beat_cnt
  );

endinterface
`default_nettype wire

// File: rtl/mac_skid_fifo2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mac_skid_fifo2                                                 |
// | Purpose : 2-entry in-order FIFO. Push and pop in the same cycle are both |
// |           performed, also when full. data_o is the head entry.           |
// | Ports   : clk, reset (async, active-low), push_i, pop_i, data_i,         |
// |           data_o, full_o, empty_o                                        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mac_skid_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] data_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  logic [1:0][W-1:0] mem_q, mem_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              w_do_push;
  logic              w_do_pop;

  assign empty_o   = (count_q == 2'd0);
  assign full_o    = (count_q == 2'd2);
  assign w_do_pop  = pop_i && !empty_o;
  // When full, the slot being written is the head that is popped this cycle.
  assign w_do_push = push_i && (!full_o || w_do_pop);
  assign data_o    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (w_do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (w_do_pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({w_do_push, w_do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mac_result_drain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : mac_result_drain                                               |
// | Purpose : Counts MAC accumulate beats, captures the accumulator on every |
// |           LEN-th beat, rounds/shifts/saturates it to OUT_W bits and      |
// |           queues it in a 2-entry buffer. Pulses mac_clear on the last    |
// |           beat so the MAC restarts from zero.                            |
// | Ports   : clk    - rising-edge clock                                     |
// |           reset  - asynchronous, active-low reset                        |
// |           bus    - mac_result_drain_if.master (beats in, results out,    |
// |                    mac_clear, sat_flag, beat_cnt)                        |
// | Revision: 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module mac_result_drain
  import mac_pkg::*;
#(
  parameter int ACC_W = c_acc_w_def,
  parameter int OUT_W = c_out_w_def,
  parameter int SHIFT = 8,
  parameter int LEN   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  mac_result_drain_if.master     bus
);

  localparam int               CNT_W  = $clog2(LEN) + 1;
  localparam logic [CNT_W-1:0] c_last = CNT_W'(LEN - 1);

  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             sat_q, sat_d;

  logic             w_is_last;
  logic             w_full;
  logic             w_empty;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic [63:0]      w_acc_ext;
  quant_t           w_quant;
  logic [OUT_W-1:0] w_quant_data;
  logic             w_unused_quant_hi;

  assign w_is_last = (beat_cnt_q == c_last);

  // Only a last beat into a full buffer with no pop this cycle can stall.
  assign bus.acc_ready = !(w_is_last && w_full && !bus.out_ready);

  // Gated by reset so mac_clear stays low while reset is asserted, even for
  // LEN==1 where every beat is a last beat.
  assign w_accept      = bus.acc_valid && bus.acc_ready && reset;
  assign w_push        = w_accept && w_is_last;
  assign w_pop         = !w_empty && bus.out_ready;
  assign bus.mac_clear = w_push;

  // Quantizer: sign-extend to 64 bits so the rounding add has headroom.
  assign w_acc_ext         = {{(64-ACC_W){bus.acc_in[ACC_W-1]}}, bus.acc_in};
  assign w_quant           = quantize($signed(w_acc_ext), SHIFT, OUT_W);
  assign w_quant_data      = w_quant.value[OUT_W-1:0];
  assign w_unused_quant_hi = ^w_quant.value[63:OUT_W];

  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (w_accept) begin
      beat_cnt_d = w_is_last ? '0 : beat_cnt_q + 1'b1;
    end
  end

  assign sat_d = sat_q | (w_push & w_quant.sat);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt_q <= '0;
      sat_q      <= 1'b0;
    end else begin
      beat_cnt_q <= beat_cnt_d;
      sat_q      <= sat_d;
    end
  end

  mac_skid_fifo2 #(
    .W (OUT_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_quant_data),
    .data_o  (bus.out_data),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign bus.out_valid = !w_empty;
  assign bus.sat_flag  = sat_q;
  assign bus.beat_cnt  = beat_cnt_q;

endmodule
`default_nettype wire
